// File: rtl/rsub_div_pkg.sv
// rtl/rsub_div_pkg.sv - shared types and constants for the repeated-subtraction divider
//
// Purpose: FSM state encoding and default operand width used by rsub_divider
//          and its helpers.
// Contents:
//   RSUB_DIV_W_DEFAULT : default operand/quotient/remainder width (8)
//   rsub_div_state_t   : IDLE / CALC / DONE
package rsub_div_pkg;

  localparam int RSUB_DIV_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } rsub_div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - operand magnitude and result sign correction for signed division
//
// Purpose: purely combinational helper used only when RSUB_DIVIDER_SIGNED_EN is
//          defined. It turns two's-complement operands into unsigned magnitudes
//          plus result sign bits, and re-applies those signs to the unsigned
//          quotient/remainder magnitudes.
// Ports:
//   dividend_i, divisor_i : raw two's-complement operands
//   q_mag_i, r_mag_i      : unsigned quotient / remainder magnitudes
//   q_neg_i, r_neg_i      : registered result signs to apply
//   a_mag_o, b_mag_o      : operand magnitudes (|dividend|, |divisor|)
//   q_neg_o, r_neg_o      : result signs derived from the raw operands
//   quotient_o            : sign-corrected quotient
//   remainder_o           : sign-corrected remainder
module div_sign_fix #(
  parameter int W = 8
) (
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  input  logic [W-1:0] q_mag_i,
  input  logic [W-1:0] r_mag_i,
  input  logic         q_neg_i,
  input  logic         r_neg_i,
  output logic [W-1:0] a_mag_o,
  output logic [W-1:0] b_mag_o,
  output logic         q_neg_o,
  output logic         r_neg_o,
  output logic [W-1:0] quotient_o,
  output logic [W-1:0] remainder_o
);

  // Negating -2^(W-1) gives 2^(W-1) again, which is the correct unsigned
  // magnitude, so the most negative value needs no special case.
  assign a_mag_o = dividend_i[W-1] ? -dividend_i : dividend_i;
  assign b_mag_o = divisor_i[W-1]  ? -divisor_i  : divisor_i;

  // Truncation toward zero: quotient sign is the XOR of operand signs,
  // remainder follows the dividend.
  assign q_neg_o = dividend_i[W-1] ^ divisor_i[W-1];
  assign r_neg_o = dividend_i[W-1];

  assign quotient_o  = q_neg_i ? -q_mag_i : q_mag_i;
  assign remainder_o = r_neg_i ? -r_mag_i : r_mag_i;

endmodule

// File: rtl/rsub_divider.sv
// rtl/rsub_divider.sv - parametrised repeated-subtraction divider with start/done handshake
//
// Purpose: multi-cycle integer divider. One subtraction per clock in CALC;
//          quotient magnitude q costs q+2 cycles from start to done.
// Configuration macro: RSUB_DIVIDER_SIGNED_EN (two's-complement operands,
//          truncation toward zero). Undefined: unsigned only.
// Ports:
//   clk       : clock, rising edge
//   clear_n   : asynchronous active-low reset
//   start     : request a division, sampled only in IDLE
//   dividend  : numerator, captured on acceptance
//   divisor   : denominator, captured on acceptance
//   busy      : high while not IDLE
//   done      : one-cycle completion pulse
//   quotient  : result quotient (held until next completion)
//   remainder : result remainder (held until next completion)
//   dz        : divide-by-zero flag of the last completed operation
module rsub_divider
  import rsub_div_pkg::*;
#(
  parameter int W = RSUB_DIV_W_DEFAULT
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         dz
);

  rsub_div_state_t state_q, state_d;

  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] quot_q, quot_d;
  logic [W-1:0] rem_q, rem_d;
  logic         dz_q, dz_d;

  logic         div_zero;
  logic         a_ge_b;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;
  logic [W-1:0] quot_res;
  logic [W-1:0] rem_res;

  assign div_zero = (divisor == '0);
  assign a_ge_b   = (a_q >= b_q);

`ifdef RSUB_DIVIDER_SIGNED_EN
  logic q_neg_q, q_neg_d;
  logic r_neg_q, r_neg_d;
  logic q_neg_in, r_neg_in;

  div_sign_fix #(.W(W)) u_sign_fix (
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .q_mag_i     (cnt_q),
    .r_mag_i     (a_q),
    .q_neg_i     (q_neg_q),
    .r_neg_i     (r_neg_q),
    .a_mag_o     (a_mag),
    .b_mag_o     (b_mag),
    .q_neg_o     (q_neg_in),
    .r_neg_o     (r_neg_in),
    .quotient_o  (quot_res),
    .remainder_o (rem_res)
  );

  // Result signs are frozen at acceptance so later operand changes are inert.
  always_comb begin
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    if (state_q == IDLE && start && !div_zero) begin
      q_neg_d = q_neg_in;
      r_neg_d = r_neg_in;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end
`else
  assign a_mag    = dividend;
  assign b_mag    = divisor;
  assign quot_res = cnt_q;
  assign rem_res  = a_q;
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = div_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (!a_ge_b) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      CALC: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next state. Result registers only move on entry to DONE.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dz_d   = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (div_zero) begin
            quot_d = '1;
            rem_d  = dividend;
            dz_d   = 1'b1;
          end else begin
            a_d   = a_mag;
            b_d   = b_mag;
            cnt_d = '0;
          end
        end
      end
      CALC: begin
        if (a_ge_b) begin
          a_d   = a_q - b_q;
          cnt_d = cnt_q + W'(1);
        end else begin
          quot_d = quot_res;
          rem_d  = rem_res;
          dz_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dz_q   <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dz_q   <= dz_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_rsub_divider.sv
// tb/tb_rsub_divider.sv - scoreboard testbench for rsub_divider (W=8)
module tb_rsub_divider;

  localparam int W = 8;

  logic         clk;
  logic         clear_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dz;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t m;

  rsub_divider #(.W(W)) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cycle);
      end else begin
        m = sb.pop_front();
        chk("quotient", int'(quotient), int'(m.q));
        chk("remainder", int'(remainder), int'(m.r));
        chk("dz", int'(dz), int'(m.dz));
        chk("done_cycle", cycle, m.cyc);
      end
    end
  end

  // Drive one start pulse; lat is the hand-computed start-to-done distance.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input int lat);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    e.q   = eq;
    e.r   = er;
    e.dz  = edz;
    e.cyc = cycle + lat;
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=%0d pending expected=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int bad;
    clear_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_dz", int'(dz), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    clear_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef RSUB_DIVIDER_SIGNED_EN
    issue(8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 5);
    wait_done();
    issue(8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 5);
    wait_done();
    issue(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 130);
    wait_done();
    issue(8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b1, 1);
    wait_done();
    issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 2);
    wait_done();
    issue(8'hF4, 8'hFD, 8'd4, 8'd0, 1'b0, 6);
    wait_done();
`else
    issue(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 30);
    wait_done();
    issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 2);
    wait_done();
    issue(8'd17, 8'd0, 8'hFF, 8'd17, 1'b1, 1);
    wait_done();
    issue(8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 2);
    wait_done();
    issue(8'd7, 8'd7, 8'd1, 8'd0, 1'b0, 3);
    wait_done();
    // Worst case: busy must stay high from k+1 through k+257.
    issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 257);
    bad = 0;
    if (!busy) bad++;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (!busy) bad++;
    end
    chk("busy_gaps_255", bad, 0);
    wait_done();
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("hold_quotient", int'(quotient), 255);
    chk("hold_remainder", int'(remainder), 0);
`endif

    // Start during CALC is ignored.
    issue(8'd100, 8'd1, 8'd100, 8'd0, 1'b0, 102);
    repeat (10) @(negedge clk);
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Back-to-back: issued the cycle after done.
    issue(8'd12, 8'd4, 8'd3, 8'd0, 1'b0, 5);
    wait_done();

    // Asynchronous reset mid-CALC: outputs clear at once, no done follows.
    issue(8'd50, 8'd1, 8'd0, 8'd0, 1'b0, 0);
    void'(sb.pop_back());
    repeat (5) @(negedge clk);
    #2 clear_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_dz", int'(dz), 0);
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    repeat (60) @(negedge clk);

    issue(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 5);
    wait_done();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsub_divider.md
# rsub_divider

Parametrised unsigned/signed integer divider using repeated subtraction, with integrated control FSM and a start/done handshake. It supersedes the fixed 8-bit split datapath/controller divider: operand width is a parameter, and the block reports the remainder, flags divide-by-zero and optionally handles signed operands. It sits as a multi-cycle arithmetic unit behind any sequencer that can issue one operation and wait for `done`.

## Interface
- `W`, default 8: operand, quotient and remainder width in bits (W ≥ 2).
- `clk` input 1: single clock. All state changes on the rising edge.
- `clear_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a new division. Sampled only in IDLE.
- `dividend` input W: numerator. Captured in the cycle `start` is accepted.
- `divisor` input W: denominator. Captured with `dividend`.
- `busy` output 1: high from the cycle after acceptance until `done` deasserts.
- `done` output 1: single-cycle pulse. `quotient`, `remainder` and `dz` are valid in this cycle and held afterwards.
- `quotient` output W: result quotient.
- `remainder` output W: result remainder.
- `dz` output 1: divide-by-zero flag for the last completed operation.

## Operation
- **Reset:** `clear_n` low forces IDLE, with `busy`, `done`, `dz`, `quotient` and `remainder` all 0. This applies at any time, including mid-operation. The in-flight operation is discarded and no `done` is produced.
- **FSM:** IDLE → CALC → DONE → IDLE.
- **IDLE:**
  - If `start`=1 and `divisor`≠0: load `A`=|dividend| and `B`=|divisor| (magnitude only under the macro, otherwise raw values), clear the iteration counter `Q`, then go to CALC.
  - If `start`=1 and `divisor`=0: go directly to DONE with `dz`=1, `quotient`=all ones, `remainder`=dividend.
- **CALC, one step per cycle:**
  - If `A` ≥ `B` (unsigned compare): `A` ← `A`−`B` and `Q` ← `Q`+1.
  - Otherwise: register `quotient`=`Q` and `remainder`=`A` (sign-corrected under the macro), set `dz`=0, and go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE. `start` is accepted again in the following cycle.
- **Start handling:**
  - `start` in CALC or DONE is ignored, not queued.
  - Operand changes after acceptance have no effect.
- **Arithmetic:**
  - Subtraction and comparison are W-bit unsigned on magnitudes.
  - `Q` is W bits and cannot overflow, because the maximum count is 2^W−1 (dividend all ones, divisor 1).
- **Result registers:** update only on the transition into DONE, and hold until the next completion or reset.

## Timing
- With `start` high in cycle k and quotient magnitude q:
  - Nonzero divisor: `done` is high in cycle k+q+2. `busy` is high in cycles k+1 through k+q+2.
  - Divide-by-zero: `done` and `busy` are high in cycle k+1 only.
- Worst case (W=8, 255/1): `done` is high in cycle k+257.
- Minimum issue interval is q+3 cycles, because the next `start` can be accepted in cycle k+q+3.
- `quotient`, `remainder` and `dz` change only in the cycle `done` rises.

## Configuration
- **Macro:** `RSUB_DIVIDER_SIGNED_EN`.
- **Defined:** operands are two's complement.
  - Magnitudes are taken at acceptance.
  - Quotient sign is `dividend[W-1]` XOR `divisor[W-1]`, giving truncation toward zero.
  - Remainder takes the sign of the dividend.
  - −2^(W−1) / −1 yields `quotient`=−2^(W−1) (wraps) and `remainder`=0, with no flag.
  - Divide-by-zero behaviour is unchanged: `quotient`=all ones and `remainder`=dividend as given.
- **Undefined:** all operands are unsigned, and no sign logic is synthesised.

## Structure
- Shared package `rsub_div_pkg`:
  - state enum typedef `rsub_div_state_t` (IDLE, CALC, DONE);
  - default width constant `RSUB_DIV_W_DEFAULT` = 8.
- One sub-module, `div_sign_fix`, instantiated only under the macro. It is combinational and does two jobs:
  - produce operand magnitudes and the result sign bits;
  - apply the sign correction to the quotient and remainder.
- FSM, magnitude registers, compare/subtract step and the counter all stay in `rsub_divider`.

## Test plan
All scenarios use W=8.
- **Basic division:** 200/7 → `quotient`=28, `remainder`=4, `dz`=0; `done` in cycle k+30.
- **Dividend smaller than divisor:** 5/9 → `quotient`=0, `remainder`=5; `done` in cycle k+2.
- **Worst-case latency:** 255/1 → `quotient`=255, `remainder`=0; `done` in cycle k+257; `busy` continuous throughout.
- **Divide-by-zero:** 17/0 → `dz`=1, `quotient`=0xFF, `remainder`=17; `done` in cycle k+1.
- **Busy and reset behaviour:**
  - pulse `start` with 9/3 mid-CALC of 100/1 → ignored; results are 100 and 0;
  - then drop `clear_n` during CALC → all outputs 0 immediately, no `done`.
- **Signed mode (macro defined):**
  - −7/2 → `quotient`=0xFD, `remainder`=0xFF;
  - 7/−2 → `quotient`=0xFD, `remainder`=0x01;
  - −128/−1 → `quotient`=0x80, `remainder`=0.
